// File: rtl/seg_display_scheduler.sv
// Round-robin display scheduler: grants one of four requesters, converts its 13-bit
// value to BCD by double-dabble, then shows the digits for DWELL cycles.
module seg_display_scheduler #(
   parameter int unsigned DWELL = 100000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  req,
   input  logic [12:0] val0,
   input  logic [12:0] val1,
   input  logic [12:0] val2,
   input  logic [12:0] val3,
   input  logic        hold,
   output logic [3:0]  gnt,
   output logic [1:0]  cur_src,
   output logic [3:0]  thousands,
   output logic [3:0]  hundreds,
   output logic [3:0]  tens,
   output logic [3:0]  ones,
   output logic        digits_valid,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, CONVERT, SHOW} state_t;

   state_t      state;
   logic [12:0] bin_q;
   logic [15:0] bcd_q;
   logic [3:0]  iter_q;
   logic [26:0] dwell_q;

   logic        dwell_done;
   logic        pick_any;
   logic [1:0]  pick_idx;
   logic [1:0]  cand;
   logic        grant_now;
   logic [1:0]  grant_idx;
   logic [12:0] grant_val;
   logic [15:0] bcd_adj;
   logic [15:0] bcd_nxt;
   logic [12:0] bin_nxt;

   function automatic logic [3:0] add3(input logic [3:0] d);
      return (d >= 4'd5) ? d + 4'd3 : d;
   endfunction

   assign dwell_done = (dwell_q == 27'(DWELL - 1));

   // Search starts one past the last grant, so the current source is checked last.
   always_comb begin
      pick_any = 1'b0;
      pick_idx = cur_src;
      cand     = cur_src;
      for (int k = 1; k <= 4; k++) begin
         cand = cur_src + 2'(k);
         if (!pick_any && req[cand]) begin
            pick_any = 1'b1;
            pick_idx = cand;
         end
      end
   end

   // Handshake: a requester holds req[i] high until it sees gnt[i]; gnt stays fixed
   // from the grant edge through the final SHOW cycle, and req is only sampled at
   // IDLE or at dwell expiry.
   always_comb begin
      grant_now = 1'b0;
      grant_idx = pick_idx;
      case (state)
         IDLE: grant_now = pick_any;
         SHOW: begin
            if (dwell_done) begin
               if (hold && req[cur_src]) begin
                  grant_now = 1'b1;
                  grant_idx = cur_src;
               end else begin
                  grant_now = pick_any;
               end
            end
         end
         default: grant_now = 1'b0;
      endcase
   end

   always_comb begin
      case (grant_idx)
         2'd0:    grant_val = val0;
         2'd1:    grant_val = val1;
         2'd2:    grant_val = val2;
         default: grant_val = val3;
      endcase
   end

   always_comb begin
      bcd_adj = {add3(bcd_q[15:12]), add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
      {bcd_nxt, bin_nxt} = {bcd_adj[14:0], bin_q, 1'b0};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         gnt          <= 4'b0000;
         cur_src      <= 2'd3;
         thousands    <= 4'd0;
         hundreds     <= 4'd0;
         tens         <= 4'd0;
         ones         <= 4'd0;
         digits_valid <= 1'b0;
         busy         <= 1'b0;
         bin_q        <= 13'd0;
         bcd_q        <= 16'd0;
         iter_q       <= 4'd0;
         dwell_q      <= 27'd0;
      end else begin
         digits_valid <= 1'b0;
         if (grant_now) begin
            state   <= CONVERT;
            gnt     <= 4'b0001 << grant_idx;
            cur_src <= grant_idx;
            bin_q   <= grant_val;
            bcd_q   <= 16'd0;
            iter_q  <= 4'd0;
            busy    <= 1'b1;
         end else begin
            case (state)
               CONVERT: begin
                  bin_q  <= bin_nxt;
                  bcd_q  <= bcd_nxt;
                  iter_q <= iter_q + 4'd1;
                  if (iter_q == 4'd12) begin
                     thousands    <= bcd_nxt[15:12];
                     hundreds     <= bcd_nxt[11:8];
                     tens         <= bcd_nxt[7:4];
                     ones         <= bcd_nxt[3:0];
                     digits_valid <= 1'b1;
                     dwell_q      <= 27'd0;
                     busy         <= 1'b0;
                     state        <= SHOW;
                  end
               end
               SHOW: begin
                  if (dwell_done) begin
                     state <= IDLE;
                     gnt   <= 4'b0000;
                  end else begin
                     dwell_q <= dwell_q + 27'd1;
                  end
               end
               IDLE: state <= IDLE;
               default: begin
                  state <= IDLE;
                  gnt   <= 4'b0000;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Directed bench for seg_display_scheduler: a table of single-grant conversions
// followed by hand-written round-robin, hold, reset-abort and req-drop sequences.
module tb_seg_display_scheduler;

   localparam int DWELL = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [12:0] val0, val1, val2, val3;
   logic        hold;
   logic [3:0]  gnt;
   logic [1:0]  cur_src;
   logic [3:0]  thousands, hundreds, tens, ones;
   logic        digits_valid;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   seg_display_scheduler #(.DWELL(DWELL)) dut (
      .clk(clk), .rst(rst), .req(req),
      .val0(val0), .val1(val1), .val2(val2), .val3(val3),
      .hold(hold), .gnt(gnt), .cur_src(cur_src),
      .thousands(thousands), .hundreds(hundreds), .tens(tens), .ones(ones),
      .digits_valid(digits_valid), .busy(busy)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [3:0]  req;
      logic [12:0] v0;
      logic [12:0] v1;
      logic [12:0] v2;
      logic [12:0] v3;
      logic [1:0]  src;
      logic [15:0] bcd;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] digits();
      return {thousands, hundreds, tens, ones};
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; req = 4'b0; hold = 1'b0;
      val0 = '0; val1 = '0; val2 = '0; val3 = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Returns at the negedge following a grant edge (busy rising).
   task automatic wait_grant(output bit ok);
      logic prev;
      ok = 1'b0;
      prev = busy;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (busy && !prev) begin
            ok = 1'b1;
            return;
         end
         prev = busy;
      end
   endtask

   task automatic wait_dv(output bit ok, output int lat);
      ok = 1'b0;
      lat = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         lat++;
         if (digits_valid) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (gnt == 4'b0 && !busy) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   // scoreboard: expected digits queue for the round-robin sequence
   logic [15:0] exp_q [$];

   initial begin
      bit ok;
      int lat;
      int last;
      int bad_cnt;
      logic [15:0] exp_d;

      vecs[0] = '{4'b0001, 13'd1234, 13'd0,    13'd0,    13'd0,    2'd0, 16'h1234};
      vecs[1] = '{4'b1010, 13'd0,    13'd8191, 13'd0,    13'd77,   2'd1, 16'h8191};
      vecs[2] = '{4'b1001, 13'd0,    13'd0,    13'd0,    13'd1000, 2'd3, 16'h1000};
      vecs[3] = '{4'b0101, 13'd0,    13'd0,    13'd4095, 13'd0,    2'd0, 16'h0000};
      vecs[4] = '{4'b0100, 13'd0,    13'd0,    13'd4095, 13'd0,    2'd2, 16'h4095};
      vecs[5] = '{4'b0100, 13'd0,    13'd0,    13'd5,    13'd0,    2'd2, 16'h0005};
      vecs[6] = '{4'b0011, 13'd999,  13'd42,   13'd0,    13'd0,    2'd0, 16'h0999};

      // reset state
      rst = 1'b1; req = 4'b0; hold = 1'b0;
      val0 = '0; val1 = '0; val2 = '0; val3 = '0;
      repeat (3) @(negedge clk);
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_cur_src", 32'(cur_src), 32'd3);
      check("rst_digits", 32'(digits()), 32'h0);
      check("rst_dv", 32'(digits_valid), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_gnt", 32'(gnt), 32'h0);

      // table-driven single grants
      for (int v = 0; v < 7; v++) begin
         req = vecs[v].req;
         val0 = vecs[v].v0; val1 = vecs[v].v1; val2 = vecs[v].v2; val3 = vecs[v].v3;
         wait_grant(ok);
         check($sformatf("v%0d_grant_seen", v), 32'(ok), 32'd1);
         check($sformatf("v%0d_gnt", v), 32'(gnt), 32'(4'b0001 << vecs[v].src));
         check($sformatf("v%0d_cur_src", v), 32'(cur_src), 32'(vecs[v].src));
         wait_dv(ok, lat);
         check($sformatf("v%0d_dv_seen", v), 32'(ok), 32'd1);
         check($sformatf("v%0d_latency", v), 32'(lat), 32'd13);
         check($sformatf("v%0d_digits", v), 32'(digits()), 32'(vecs[v].bcd));
         req = 4'b0;
         wait_idle(ok);
         check($sformatf("v%0d_idle", v), 32'(ok), 32'd1);
         check($sformatf("v%0d_retained", v), 32'(digits()), 32'(vecs[v].bcd));
      end

      // round robin with all four requesting
      do_reset();
      val0 = 13'd11; val1 = 13'd22; val2 = 13'd33; val3 = 13'd44;
      exp_q = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0011};
      req = 4'b1111;
      last = 0;
      for (int k = 0; k < 5; k++) begin
         wait_grant(ok);
         check($sformatf("rr%0d_grant_seen", k), 32'(ok), 32'd1);
         check($sformatf("rr%0d_gnt", k), 32'(gnt), 32'(4'b0001 << (k % 4)));
         if (k > 0) check($sformatf("rr%0d_interval", k), 32'(cyc - last), 32'd21);
         last = cyc;
         wait_dv(ok, lat);
         exp_d = exp_q.pop_front();
         check($sformatf("rr%0d_digits", k), 32'(digits()), 32'(exp_d));
      end
      req = 4'b0;
      wait_idle(ok);
      check("rr_idle", 32'(ok), 32'd1);

      // hold re-grants source 0 with a fresh capture; val0 change during CONVERT ignored
      do_reset();
      val0 = 13'd1111; val1 = 13'd2222;
      req = 4'b0011;
      wait_grant(ok);
      check("hold_first_gnt", 32'(gnt), 32'h1);
      wait_dv(ok, lat);
      check("hold_first_digits", 32'(digits()), 32'h1111);
      repeat (2) @(negedge clk);
      hold = 1'b1;
      val0 = 13'd4321;
      wait_grant(ok);
      check("hold_regrant_seen", 32'(ok), 32'd1);
      check("hold_regrant_gnt", 32'(gnt), 32'h1);
      val0 = 13'd7777;
      wait_dv(ok, lat);
      check("hold_regrant_digits", 32'(digits()), 32'h4321);
      hold = 1'b0;
      wait_grant(ok);
      check("nohold_gnt", 32'(gnt), 32'h2);
      wait_dv(ok, lat);
      check("nohold_digits", 32'(digits()), 32'h2222);
      req = 4'b0;
      wait_idle(ok);

      // reset on the 6th CONVERT cycle aborts the conversion
      do_reset();
      val0 = 13'd1234;
      req = 4'b0001;
      wait_grant(ok);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      req = 4'b0;
      @(negedge clk);
      check("abort_busy", 32'(busy), 32'h0);
      check("abort_gnt", 32'(gnt), 32'h0);
      check("abort_digits", 32'(digits()), 32'h0);
      check("abort_cur_src", 32'(cur_src), 32'd3);
      rst = 1'b0;
      bad_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (digits_valid) bad_cnt++;
         @(negedge clk);
      end
      check("abort_no_dv", 32'(bad_cnt), 32'd0);

      // req dropped during SHOW: full dwell then IDLE with digits kept
      val1 = 13'd567;
      req = 4'b0010;
      wait_grant(ok);
      wait_dv(ok, lat);
      req = 4'b0;
      bad_cnt = 0;
      for (int i = 0; i < DWELL - 1; i++) begin
         @(negedge clk);
         if (gnt !== 4'b0010) bad_cnt++;
      end
      check("drop_gnt_held", 32'(bad_cnt), 32'd0);
      @(negedge clk);
      check("drop_gnt_cleared", 32'(gnt), 32'h0);
      check("drop_busy", 32'(busy), 32'h0);
      check("drop_digits", 32'(digits()), 32'h0567);
      check("drop_cur_src", 32'(cur_src), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
